// File: rtl/arbiter_req_agent_if.sv
// Requester-side handshake bundle: producer push channel, arbiter req/grant pair and status.
interface arbiter_req_agent_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              req;
  logic              grant;
  logic [DATA_W-1:0] out_data;
  logic [LVL_W-1:0]  level;
  logic              starve;
  logic              grant_err;

  // agent side
  modport slave (
    input  in_valid, in_data, grant,
    output in_ready, req, out_data, level, starve, grant_err
  );

  // producer / arbiter side
  modport master (
    output in_valid, in_data, grant,
    input  in_ready, req, out_data, level, starve, grant_err
  );
endinterface

// File: rtl/arbiter_req_agent.sv
// Arbitrated-source endpoint: FWFT FIFO feeding req/grant, with starvation and stray-grant monitors.
module arbiter_req_agent #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 4,
  parameter int CNT_W     = 8,
  parameter int STARVE_TH = 64
) (
  input  logic             clk,
  input  logic             rst,
  arbiter_req_agent_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] TH = CNT_W'(STARVE_TH);

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;
  logic             full, empty, push, pop;

  // Flags come from registered pointers only, so req/in_ready never depend on grant/in_valid.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push  = bus.in_valid & ~full;
  assign pop   = bus.grant & ~empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) mem[wr_ptr[AW-1:0]] <= bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst)                   wait_cnt <= '0;
    else if (pop || empty)      wait_cnt <= '0;
    else if (wait_cnt != '1)    wait_cnt <= wait_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst)                   err_q <= 1'b0;
    else if (bus.grant && empty) err_q <= 1'b1;
  end

  assign bus.in_ready  = ~full;
  assign bus.req       = ~empty;
  assign bus.out_data  = mem[rd_ptr[AW-1:0]];
  assign bus.level     = wr_ptr - rd_ptr;
  assign bus.starve    = (wait_cnt >= TH);
  assign bus.grant_err = err_q;
endmodule

// File: tb/tb_arbiter_req_agent.sv
// Directed + random bench for arbiter_req_agent against a queue-based reference model.
module tb_arbiter_req_agent;
  localparam int DATA_W = 8, DEPTH = 4, CNT_W = 8, STARVE_TH = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  arbiter_req_agent_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus();

  arbiter_req_agent #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .STARVE_TH(STARVE_TH))
    dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0, errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: occupancy is the queue, wait count is plain integer arithmetic.
  logic [DATA_W-1:0] q[$];
  int  wc = 0;
  bit  gerr = 1'b0;

  always @(posedge clk) begin
    bit popped, pushed;
    if (!rst) begin
      q.delete();
      wc = 0;
      gerr = 1'b0;
    end else begin
      popped = (q.size() > 0) && bus.grant;
      pushed = bus.in_valid && (q.size() < DEPTH);
      if (bus.grant && q.size() == 0) gerr = 1'b1;
      if (popped || q.size() == 0) wc = 0;
      else if (wc < (1 << CNT_W) - 1) wc++;
      if (popped) void'(q.pop_front());
      if (pushed) q.push_back(bus.in_data);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req",       32'(bus.req),       32'(q.size() > 0));
      chk("in_ready",  32'(bus.in_ready),  32'(q.size() < DEPTH));
      chk("level",     32'(bus.level),     32'(q.size()));
      chk("starve",    32'(bus.starve),    32'(wc >= STARVE_TH));
      chk("grant_err", 32'(bus.grant_err), 32'(gerr));
      if (q.size() > 0) chk("out_data", 32'(bus.out_data), 32'(q[0]));
    end
  end

  // Inputs change just after the falling edge; the following rising edge samples them.
  task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic g);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.grant    = g;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.grant = 1'b0;
    step(0, 0, 0);
    chk_en = 1'b1;
    step(0, 0, 0);
    rst = 1'b1;
    chk("rst_req", 32'(bus.req), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_starve", 32'(bus.starve), 0);
    chk("rst_grant_err", 32'(bus.grant_err), 0);

    // single push then single grant
    step(1, 8'hA1, 0);
    chk("t1_req", 32'(bus.req), 1);
    chk("t1_data", 32'(bus.out_data), 32'h A1);
    chk("t1_level", 32'(bus.level), 1);
    chk("t1_in_ready", 32'(bus.in_ready), 1);
    step(0, 0, 1);
    chk("t1_level_after", 32'(bus.level), 0);
    chk("t1_req_after", 32'(bus.req), 0);

    // fill, overflow push dropped, drain in order
    for (int i = 0; i < 4; i++) step(1, 8'(8'h10 + i), 0);
    chk("t2_level_full", 32'(bus.level), 4);
    chk("t2_in_ready", 32'(bus.in_ready), 0);
    step(1, 8'h14, 0);
    chk("t2_level_drop", 32'(bus.level), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_order", 32'(bus.out_data), 32'(8'h10 + i));
      step(0, 0, 1);
    end
    chk("t2_req_empty", 32'(bus.req), 0);

    // steady-state push+pop at level 2 across two pointer wraps
    step(1, 8'h20, 0);
    step(1, 8'h21, 0);
    for (int i = 0; i < 10; i++) begin
      chk("t3_order", 32'(bus.out_data), 32'(8'h20 + i));
      step(1, 8'(8'h22 + i), 1);
      chk("t3_level", 32'(bus.level), 2);
    end
    step(0, 0, 1);
    step(0, 0, 1);
    chk("t3_drained", 32'(bus.req), 0);

    // starvation threshold
    step(1, 8'h55, 0);
    for (int k = 1; k <= 6; k++) begin
      step(0, 0, 0);
      chk("t4_starve", 32'(bus.starve), 32'(k >= STARVE_TH));
    end
    step(0, 0, 1);
    chk("t4_starve_clear", 32'(bus.starve), 0);
    chk("t4_req", 32'(bus.req), 0);

    // stray grant
    step(0, 0, 1);
    chk("t5_grant_err", 32'(bus.grant_err), 1);
    chk("t5_level", 32'(bus.level), 0);
    step(1, 8'h66, 0);
    step(0, 0, 1);
    chk("t5_sticky", 32'(bus.grant_err), 1);

    // reset mid-operation
    for (int i = 0; i < 3; i++) step(1, 8'(8'h70 + i), 0);
    chk("t6_level_pre", 32'(bus.level), 3);
    rst = 1'b0;
    step(1, 8'h7F, 1);
    rst = 1'b1;
    chk("t6_level", 32'(bus.level), 0);
    chk("t6_req", 32'(bus.req), 0);
    chk("t6_in_ready", 32'(bus.in_ready), 1);
    chk("t6_starve", 32'(bus.starve), 0);
    chk("t6_grant_err", 32'(bus.grant_err), 0);

    // random: balanced traffic, then grant-starved traffic
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 199) != 0);
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    end
    rst = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 499) != 0);
      step(1'($urandom_range(0, 4) == 0), 8'($urandom), 1'($urandom_range(0, 11) == 0));
    end
    rst = 1'b1;
    step(0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
